// File: rtl/popcount_share_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// popcount_ctrl_pkg
//
// Shared definitions for the popcount sharing controller:
//   IN_W       width of one input beat fed to the popcount unit
//   PC_W       width of the popcount unit result
//   MAX_ACC_W  widest accumulator the saturating adder supports
//   ctrl_state_t  controller states (ARB: no owner, BURST: owner locked)
//   sat_add    saturating accumulate of a popcount into an accumulator
// ---------------------------------------------------------------------------
package popcount_ctrl_pkg;

   localparam int IN_W      = 28;
   localparam int PC_W      = 5;
   localparam int MAX_ACC_W = 32;

   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } ctrl_state_t;

   typedef struct packed {
      logic                 ovf;
      logic [MAX_ACC_W-1:0] sum;
   } sat_res_t;

   // Adds a popcount to an accumulator that is accW bits wide. The sum is
   // formed one bit wider than the widest accumulator so the carry is never
   // lost. Anything above 2^accW-1 is clamped and flagged as overflow.
   // Callers pass their accumulator zero-extended to MAX_ACC_W bits.
   function automatic sat_res_t sat_add(input logic [MAX_ACC_W-1:0] acc,
                                        input logic [PC_W-1:0]      pc,
                                        input int                   accW);
      logic [MAX_ACC_W:0] full;
      logic [MAX_ACC_W:0] maxVal;
      sat_res_t           res;
      full   = {1'b0, acc} + {{(MAX_ACC_W + 1 - PC_W){1'b0}}, pc};
      maxVal = ({{MAX_ACC_W{1'b0}}, 1'b1} << accW) - {{MAX_ACC_W{1'b0}}, 1'b1};
      if (full > maxVal) begin
         res.ovf = 1'b1;
         res.sum = maxVal[MAX_ACC_W-1:0];
      end else begin
         res.ovf = 1'b0;
         res.sum = full[MAX_ACC_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/popcount_share_ctrl_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin arbiter. Picks the first asserted request
// scanning upward from ptr and wrapping around.
//   req  in   NREQ   request vector
//   ptr  in   PTR_W  index that has highest priority this cycle
//   gnt  out  NREQ   one-hot grant, all zero when no request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt
);

   logic [NREQ-1:0] rotReq;
   logic            found;
   int              pick;

   // Rotate the request vector so that bit 0 is the requester at ptr, take
   // the lowest set bit of the rotated vector, then map that position back
   // to the real requester index modulo NREQ.
   always_comb begin
      rotReq = NREQ'({req, req} >> ptr);
      found  = 1'b0;
      pick   = 0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && rotReq[k]) begin
            found = 1'b1;
            pick  = (int'(ptr) + k) % NREQ;
         end
      end
      gnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt[i] = found && (pick == i);
      end
   end

endmodule

// File: rtl/popcount_share_ctrl.sv
// ---------------------------------------------------------------------------
// popcount_share_ctrl
//
// Shares one external combinational 28-input popcount unit among NREQ
// requesters. Arbitrates round-robin, locks the unit to one owner for a
// multi-beat transaction, accumulates the popcount of every beat into a
// saturating sum and returns one result per transaction.
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   req_valid   per-requester beat valid
//   req_last    per-requester final beat of a transaction
//   req_data    per-requester 28-bit beat, requester i at [28*i+27:28*i]
//   req_ready   per-requester beat accept (one-hot or zero)
//   pc_in       vector driven to the popcount unit (zero when idle)
//   pc_out      popcount of pc_in, combinational
//   rsp_valid   result available
//   rsp_ready   result consumed
//   rsp_id      requester that owns the result
//   rsp_sum     saturated popcount sum of the transaction
//   rsp_sat     sum saturated during the transaction
// ACC_W may not exceed popcount_ctrl_pkg::MAX_ACC_W.
// ---------------------------------------------------------------------------
module popcount_share_ctrl
   import popcount_ctrl_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int ACC_W = 8,
   parameter int ID_W  = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_last,
   input  logic [NREQ*IN_W-1:0]   req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic [IN_W-1:0]        pc_in,
   input  logic [PC_W-1:0]        pc_out,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [ACC_W-1:0]       rsp_sum,
   output logic                   rsp_sat
);

   ctrl_state_t       state_q, state_d;
   logic [ID_W-1:0]   rrPtr_q, rrPtr_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              sat_q, sat_d;
   logic              rspValid_q, rspValid_d;
   logic [ID_W-1:0]   rspId_q, rspId_d;
   logic [ACC_W-1:0]  rspSum_q, rspSum_d;
   logic              rspSat_q, rspSat_d;

   logic [NREQ-1:0]   arbGnt;
   logic [NREQ-1:0]   gnt;
   logic [ID_W-1:0]   gntIdx;
   logic              canAccept;
   logic              beatAcc;
   logic              lastAcc;
   sat_res_t          addRes;
   logic [ACC_W-1:0]  addSum;
   logic              addOvf;

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (ID_W)
   ) uArb (
      .req (req_valid),
      .ptr (rrPtr_q),
      .gnt (arbGnt)
   );

   // Grant and datapath. In ARB the arbiter picks a requester; in BURST only
   // the owner may proceed, even if it has dropped valid. A pending response
   // that is not being consumed blocks every beat, so a result is never
   // overwritten. Beats are also refused while reset is asserted so that
   // req_ready and pc_in sit at their idle values during reset. pc_in is
   // forced to zero unless a beat is actually being accepted to avoid
   // toggling the popcount unit needlessly.
   always_comb begin
      canAccept = !rst && (!rspValid_q || rsp_ready);
      gnt       = '0;
      if (state_q == BURST) begin
         for (int i = 0; i < NREQ; i++) begin
            gnt[i] = (owner_q == ID_W'(i));
         end
      end else begin
         gnt = arbGnt;
      end
      req_ready = canAccept ? (gnt & req_valid) : '0;
      gntIdx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gntIdx = ID_W'(i);
         end
      end
      pc_in = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            pc_in = req_data[IN_W*i +: IN_W];
         end
      end
      beatAcc = |req_ready;
      lastAcc = |(req_ready & req_last);
      addRes  = sat_add(MAX_ACC_W'(acc_q), pc_out, ACC_W);
      addSum  = ACC_W'(addRes.sum);
      addOvf  = addRes.ovf;
   end

   // Next-state logic. A consumed response clears rsp_valid first; a last
   // beat accepted in the same cycle then reloads the response registers and
   // sets rsp_valid again, so back-to-back results flow at one per cycle.
   // A non-last beat locks the owner and moves to BURST; a last beat hands
   // priority to the requester after the one just served.
   always_comb begin
      state_d    = state_q;
      rrPtr_d    = rrPtr_q;
      owner_d    = owner_q;
      acc_d      = acc_q;
      sat_d      = sat_q;
      rspValid_d = rspValid_q;
      rspId_d    = rspId_q;
      rspSum_d   = rspSum_q;
      rspSat_d   = rspSat_q;
      if (rspValid_q && rsp_ready) begin
         rspValid_d = 1'b0;
      end
      if (beatAcc) begin
         if (lastAcc) begin
            rspSum_d   = addSum;
            rspSat_d   = sat_q | addOvf;
            rspId_d    = gntIdx;
            rspValid_d = 1'b1;
            acc_d      = '0;
            sat_d      = 1'b0;
            rrPtr_d    = (gntIdx == ID_W'(NREQ - 1)) ? '0 : gntIdx + ID_W'(1);
            state_d    = ARB;
         end else begin
            acc_d   = addSum;
            sat_d   = sat_q | addOvf;
            owner_d = gntIdx;
            state_d = BURST;
         end
      end
   end

   // State registers. Reset drops any partial transaction; the requester has
   // to start it again from its first beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ARB;
         rrPtr_q    <= '0;
         owner_q    <= '0;
         acc_q      <= '0;
         sat_q      <= 1'b0;
         rspValid_q <= 1'b0;
         rspId_q    <= '0;
         rspSum_q   <= '0;
         rspSat_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rrPtr_q    <= rrPtr_d;
         owner_q    <= owner_d;
         acc_q      <= acc_d;
         sat_q      <= sat_d;
         rspValid_q <= rspValid_d;
         rspId_q    <= rspId_d;
         rspSum_q   <= rspSum_d;
         rspSat_q   <= rspSat_d;
      end
   end

   assign rsp_valid = rspValid_q;
   assign rsp_id    = rspId_q;
   assign rsp_sum   = rspSum_q;
   assign rsp_sat   = rspSat_q;

endmodule

// File: doc/popcount_share_ctrl.md
# popcount_share_ctrl

Sequential controller that shares one combinational 28-input popcount unit (exact or approximate variant, instantiated outside this block) among NREQ requesting neurons. It arbitrates round-robin, locks the unit to one requester for a multi-beat transaction, and accumulates the 5-bit popcount of each 28-bit beat into a saturating sum. It returns one result per transaction over a valid/ready response port. It sits between the neuron input-vector sequencers and the popcount datapath in the printed ternary-neuron pipeline.

## Interface
- NREQ, 4: number of requesters, 2..8
- ACC_W, 8: accumulator / result width, at least 5
- ID_W, $clog2(NREQ): response id width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester beat valid
- req_last  in  NREQ  per-requester final beat of transaction
- req_data  in  NREQ*28  per-requester 28-bit vector; requester i uses bits [28*i+27:28*i]
- req_ready  out  NREQ  per-requester beat accept, one-hot or zero
- pc_in  out  28  vector driven to the shared popcount unit
- pc_out  in  5  popcount unit result, combinational from pc_in
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_id  out  ID_W  requester that owns the result
- rsp_sum  out  ACC_W  accumulated popcount
- rsp_sat  out  1  accumulator saturated during the transaction

## Operation
- States:
  - ARB: no owner.
  - BURST: owner locked. A transaction has started and its last beat is not yet accepted.
- Grant:
  - In ARB, grant goes to the first requester with req_valid set, scanning from rr_ptr upward and wrapping.
  - In BURST, grant goes only to the owner.
- can_accept = !rsp_valid || rsp_ready.
- req_ready[g] = can_accept && req_valid[g] for the granted g. All other bits are 0.
- pc_in = req_data of the granted requester when req_ready[g] is high, else 28'h0. The all-zero default limits toggling.
- Beat accepted (req_valid & req_ready) with req_last=0:
  - acc <= sat_add(acc, pc_out)
  - sat <= sat | overflow
  - owner <= g
  - ARB→BURST, or stay in BURST
- Beat accepted with req_last=1:
  - rsp_sum <= sat_add(acc, pc_out)
  - rsp_sat <= sat | overflow
  - rsp_id <= g
  - rsp_valid <= 1
  - acc <= 0, sat <= 0
  - rr_ptr <= (g+1) mod NREQ
  - next state ARB
- A single-beat transaction (req_last on the first beat) never enters BURST.
- sat_add: zero-extend pc_out to ACC_W+1 bits and add. If the result exceeds 2^ACC_W−1, clamp to 2^ACC_W−1 and flag overflow.
- Response: rsp_valid clears when rsp_valid && rsp_ready and no new last beat is accepted in the same cycle. The simultaneous case reloads the register and keeps rsp_valid=1.
- While rsp_valid && !rsp_ready, no beats are accepted, including non-last beats. The owner keeps its lock.
- A requester dropping req_valid mid-burst stalls the burst. The lock is not released; there is no timeout.
- Reset state: state=ARB, rr_ptr=0, acc=0, sat=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_sat=0. req_ready=0 and pc_in=0 follow combinationally.
- Reset mid-transaction discards the partial sum. The requester must restart the transaction.

## Timing
- req_ready, pc_in, and the use of pc_out within the same cycle are combinational. The popcount unit is on the cycle path: pc_in → popcount → adder → acc register.
- Latency: last beat accepted at edge t → rsp_valid=1 after edge t.
- Throughput: one beat per cycle. Back-to-back single-beat transactions from different requesters sustain 1/cycle while rsp_ready=1.
- rsp_id, rsp_sum and rsp_sat are stable while rsp_valid && !rsp_ready.

## Structure
- Package popcount_ctrl_pkg holds:
  - IN_W=28, PC_W=5
  - enum ctrl_state_t {ARB, BURST}
  - function sat_add
- Sub-module rr_arbiter (NREQ): inputs req, ptr; output one-hot gnt; purely combinational.
- The popcount unit is not instantiated here, so approximate variants can be swapped at the top level.

## Test plan
Bench ties an exact popcount model to pc_in/pc_out.
- Reset, then requester 2 sends a single beat 28'hFFFFFFF with last=1 and rsp_ready=1 → rsp_valid one cycle later, rsp_id=2, rsp_sum=28, rsp_sat=0.
- Requester 0 sends a 3-beat burst (28'h000000F, 28'h00000FF, 28'h0000001, last on beat 3) while requester 1 holds valid → req_ready[1]=0 throughout the burst, rsp_sum=13, rsp_id=0; requester 1 is granted on the next cycle.
- All four requesters hold single-beat valid continuously → grant order 0,1,2,3,0, one response per cycle.
- ACC_W=5, requester 3 sends two beats of 28'hFFFFFFF → rsp_sum=31, rsp_sat=1.
- rsp_ready=0 for 3 cycles after a response → req_ready all 0 and rsp fields stable. Raise rsp_ready together with a new last beat → rsp_valid stays 1 with the new values.
- Assert rst mid-burst (after beat 1 of 3) → all outputs reach reset values immediately. The restarted burst yields only the new beats' sum.
